// File: rtl/control_input_decoder.sv
// control_input_decoder: syncs and debounces three raw buttons, then
// emits pause/resume pulses and a saturating speed select.
module control_input_decoder #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18,
  parameter int SPEED_MIN       = 1,
  parameter int SPEED_MAX       = 6,
  parameter int SPEED_INIT      = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_pause_n,
  input  logic       btn_up_n,
  input  logic       btn_down_n,
  output logic       pause,
  output logic       resume,
  output logic [2:0] speed,
  output logic       paused_view
);

  typedef enum logic {
    S_RUN,
    S_PAUSED
  } state_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [2:0] SMIN  = 3'(SPEED_MIN);
  localparam logic [2:0] SMAX  = 3'(SPEED_MAX);
  localparam logic [2:0] SINIT = 3'(SPEED_INIT);

  // bit 0 = pause, bit 1 = up, bit 2 = down; active-high after inversion
  logic [2:0] raw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] db_q, db_d, dbd_q;
  logic [2:0] evt;
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];

  state_e     state_q, state_d;
  logic       pause_q, pause_d;
  logic       resume_q, resume_d;
  logic [2:0] speed_q, speed_d;

  assign raw = ~{btn_down_n, btn_up_n, btn_pause_n};

  // two-flop synchronizer per button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
    end
  end

  // accept a new level only after it has disagreed with db long enough
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != db_q[i]) begin
        if (cnt_q[i] == DB_LAST) begin
          db_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // debounced levels, their one-cycle delay, and stability counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db_q  <= '0;
      dbd_q <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      db_q  <= db_d;
      dbd_q <= db_q;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // rising edge of the debounced level; dbd_q resets low so a
  // button held through reset still yields one press
  assign evt = db_q & ~dbd_q;

  // pause toggle next state and pulse generation
  always_comb begin
    state_d  = state_q;
    pause_d  = 1'b0;
    resume_d = 1'b0;
    if (evt[0]) begin
      unique case (state_q)
        S_RUN: begin
          pause_d = 1'b1;
          state_d = S_PAUSED;
        end
        S_PAUSED: begin
          resume_d = 1'b1;
          state_d  = S_RUN;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // saturating speed step; bounds tested before the add/subtract
  always_comb begin
    speed_d = speed_q;
    if (evt[1] && !evt[2] && speed_q < SMAX) begin
      speed_d = speed_q + 3'd1;
    end else if (evt[2] && !evt[1] && speed_q > SMIN) begin
      speed_d = speed_q - 3'd1;
    end
  end

  // registered control outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_RUN;
      pause_q  <= 1'b0;
      resume_q <= 1'b0;
      speed_q  <= SINIT;
    end else begin
      state_q  <= state_d;
      pause_q  <= pause_d;
      resume_q <= resume_d;
      speed_q  <= speed_d;
    end
  end

  assign pause       = pause_q;
  assign resume      = resume_q;
  assign speed       = speed_q;
  assign paused_view = (state_q == S_PAUSED);

endmodule

// File: tb/tb_control_input_decoder.sv
// tb_control_input_decoder: scoreboard bench for the button decoder
// with a short debounce window.
module tb_control_input_decoder;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic       btn_pause_n;
  logic       btn_up_n;
  logic       btn_down_n;
  logic       pause;
  logic       resume;
  logic [2:0] speed;
  logic       paused_view;

  int checks = 0;
  int errors = 0;
  int sb[$];
  int ms;
  bit mp;
  int prev;

  control_input_decoder #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3),
    .SPEED_MIN(1),
    .SPEED_MAX(6),
    .SPEED_INIT(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_pause_n(btn_pause_n),
    .btn_up_n(btn_up_n),
    .btn_down_n(btn_down_n),
    .pause(pause),
    .resume(resume),
    .speed(speed),
    .paused_view(paused_view)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input int obs);
    int e;
    e = -1;
    if (sb.size() != 0) e = sb.pop_front();
    check(tag, obs, e);
  endtask

  // event codes: 8 = pause pulse, 16 = resume pulse, 24+v = speed v
  always @(negedge clk) begin
    if (rst) begin
      prev = int'(speed);
    end else begin
      if (pause && resume) check("excl", 1, 0);
      if (pause) pop_chk("pause_evt", 8);
      if (resume) pop_chk("resume_evt", 16);
      if (int'(speed) != prev) begin
        pop_chk("speed_evt", 24 + int'(speed));
        prev = int'(speed);
      end
    end
  end

  task automatic model(input bit up, input bit dn, input bit ps);
    int ns;
    ns = ms;
    if (ps) begin
      sb.push_back(mp ? 16 : 8);
      mp = !mp;
    end
    if (up && !dn) ns = (ms < 6) ? ms + 1 : 6;
    if (dn && !up) ns = (ms > 1) ? ms - 1 : 1;
    if (ns != ms) begin
      ms = ns;
      sb.push_back(24 + ns);
    end
  endtask

  task automatic press(input bit up, input bit dn, input bit ps,
                       input int hold);
    @(negedge clk);
    if (hold >= D + 1) model(up, dn, ps);
    btn_up_n    = ~up;
    btn_down_n  = ~dn;
    btn_pause_n = ~ps;
    repeat (hold) @(negedge clk);
    btn_up_n    = 1'b1;
    btn_down_n  = 1'b1;
    btn_pause_n = 1'b1;
    repeat (D + 6) @(negedge clk);
  endtask

  task automatic do_reset(input int cyc);
    @(posedge clk);
    #2 rst = 1'b1;
    ms = 1;
    mp = 1'b0;
    #1;
    check("rst_pause", int'(pause), 0);
    check("rst_resume", int'(resume), 0);
    check("rst_pview", int'(paused_view), 0);
    check("rst_speed", int'(speed), 1);
    repeat (cyc) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    btn_pause_n = 1'b1;
    btn_up_n    = 1'b1;
    btn_down_n  = 1'b1;
    ms          = 1;
    mp          = 1'b0;
    prev        = 1;
    #1;
    check("init_speed", int'(speed), 1);
    check("init_pview", int'(paused_view), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("idle_speed", int'(speed), 1);

    // short glitch must be rejected
    press(1, 0, 0, 3);
    check("glitch_speed", int'(speed), 1);

    // clean press: measure press-to-output latency in edges
    @(negedge clk);
    model(1, 0, 0);
    btn_up_n = 1'b0;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (n == 0 && speed != 3'd1) n = i;
    end
    if (n == 0) n = 21;
    check("latency", n, D + 4);
    btn_up_n = 1'b1;
    repeat (D + 6) @(negedge clk);
    check("one_step", int'(speed), 2);

    // asynchronous reset mid-run, then quiet
    do_reset(3);
    repeat (20) @(negedge clk);

    // saturation both ways
    for (int i = 0; i < 7; i++) press(1, 0, 0, 7);
    check("sat_hi", int'(speed), 6);
    for (int i = 0; i < 7; i++) press(0, 1, 0, 7);
    check("sat_lo", int'(speed), 1);

    // toggle
    press(0, 0, 1, 7);
    check("pv_on", int'(paused_view), 1);
    press(0, 0, 1, 7);
    check("pv_off", int'(paused_view), 0);

    // simultaneous up+down+pause at speed 3
    press(1, 0, 0, 7);
    press(1, 0, 0, 7);
    press(1, 1, 1, 7);
    check("simul_speed", int'(speed), 3);
    check("simul_pv", int'(paused_view), 1);

    // held button and reset while held
    do_reset(2);
    repeat (5) @(negedge clk);
    @(negedge clk);
    model(0, 0, 1);
    btn_pause_n = 1'b0;
    repeat (100) @(negedge clk);
    check("held_pv", int'(paused_view), 1);
    check("held_drain", sb.size(), 0);
    do_reset(2);
    model(0, 0, 1);
    repeat (D + 10) @(negedge clk);
    check("rehold_pv", int'(paused_view), 1);
    btn_pause_n = 1'b1;
    repeat (D + 10) @(negedge clk);

    check("final_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
